arith_seq_checker: RTL and testbench
====================================

Name: arith_seq_checker

Overview:
- Requester/checker at the opposite end of the 4-bit add/subtract unit's operand interface.
- Drives enb, modo, A and B into the arithmetic unit, waits a fixed latency, samples Q/RCO and compares them against an internal golden model.
- Exhaustively sweeps all 256 operand pairs per selected mode and reports a saturating error count.
- Serves as the self-checking stimulus engine for bring-up and for the team's benches.

Parameters:
- LAT, 1: cycles from driving an operand pair to sampling Q/RCO; legal range 1..7.
- ERR_W, 8: width of the error counter.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a sweep when idle.
- sweep_sel  input  2  00 add only, 01 sub only, 1x add sweep then sub sweep.
- enb  output  1  enable to the arithmetic unit.
- modo  output  2  mode to the arithmetic unit: 00 add, 01 subtract.
- A  output  4  operand A.
- B  output  4  operand B.
- Q  input  4  result from the arithmetic unit.
- RCO  input  1  carry-out (add) or borrow-out (sub) from the arithmetic unit.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at sweep end.
- err_cnt  output  ERR_W  number of mismatches in the last sweep; saturating.
- pass  output  1  high after done when err_cnt==0; cleared on the next start.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - enb, busy, done, pass = 0.
  - modo=00, A=0, B=0, err_cnt=0, internal latency counter=0.
  - Reset asserted mid-sweep aborts immediately; no done pulse is issued.
- FSM states: IDLE, DRIVE, WAIT, CHECK, NEXT, FIN.
- IDLE:
  - start=1 moves to DRIVE.
  - On entry to DRIVE: A=0, B=0, err_cnt=0, pass=0, busy=1.
  - modo=01 if sweep_sel==01, otherwise 00.
  - start while busy is ignored.
- DRIVE: enb=1; A/B/modo held stable; latency counter loaded with LAT-1; go to WAIT.
- WAIT: counter decrements each cycle. When it is 0, go to CHECK. With LAT=1, WAIT lasts one cycle.
- CHECK: sample Q/RCO and compare against the golden model.
  - Add: {RCO,Q} == A+B (5-bit).
  - Sub: Q == (A-B) mod 16; RCO == (A<B).
  - On mismatch: err_cnt increments, saturating at all-ones.
- NEXT:
  - B increments.
  - On B wrap 15→0, A increments.
  - On A and B both wrapping after pair (15,15):
    - If sweep_sel[1]=1 and modo==00: modo=01, A=B=0, go to DRIVE.
    - Otherwise go to FIN.
  - Otherwise go to DRIVE.
- FIN: enb=0, busy=0, done=1 for exactly one cycle, pass=(err_cnt==0); return to IDLE.
- enb is high in DRIVE/WAIT/CHECK/NEXT and low in IDLE/FIN.
- A/B/modo change only in NEXT or on sweep entry, never while a compare is pending.
- Sweep length per pair is LAT+2 cycles.
  - One mode: 256 × (LAT+2) cycles.
  - Both modes: double that.
- start coincident with FIN is ignored; start is accepted only in IDLE.

Optional Feature:
- Macro: ARITH_SEQ_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch in CHECK goes directly to FIN with err_cnt=1 and pass=0.
  - A/B/modo hold the failing vector until the next start.
- Undefined: the sweep always runs to completion and all mismatches are counted.

Test Plan:
- Correct adder model, LAT=1, sweep_sel=00, start pulse:
  - 256 compares; done after 768 cycles.
  - err_cnt=0, pass=1.
  - Final A=15, B=15.
- Correct model, sweep_sel=10:
  - modo switches 00→01 after pair (15,15).
  - done after 1536 cycles; err_cnt=0.
- Faulty sub model forcing RCO=0, sweep_sel=01:
  - err_cnt=120 (pairs with A<B), pass=0.
  - With ARITH_SEQ_STOP_ON_ERR_EN: halts at A=0, B=1 with err_cnt=1.
- Model with Q stuck at 0, sweep_sel=1x, ERR_W=4:
  - err_cnt saturates at 15.
- rst_n pulsed low mid-sweep at A=7:
  - All outputs return to reset values asynchronously; no done pulse.
  - A subsequent start runs a full clean sweep.
- LAT=3, start pulsed again while busy:
  - The extra start is ignored.
  - Q sampled exactly 3 cycles after each DRIVE; 1280-cycle sweep.

Source files
------------

// File: rtl/arith_seq_checker.sv
// arith_seq_checker: stimulus/checker engine for the 4-bit add/subtract unit.
// Sweeps all 256 (A,B) pairs per selected mode, waits LAT cycles per pair,
// compares Q/RCO against a built-in golden model and counts mismatches
// (saturating).
// Optional build macro: ARITH_SEQ_STOP_ON_ERR_EN -- halt on the first mismatch
// and hold the failing vector on A/B/modo until the next start.
//
// Per-pair timing is LAT+2 cycles: one presentation cycle (DRIVE for the first
// pair of a mode, NEXT for every following pair), LAT cycles of WAIT, then
// CHECK. The decision taken in CHECK registers the following vector, so that
// vector is already on A/B/modo during NEXT. A/B/modo never move while a
// compare is outstanding.
module arith_seq_checker #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       sweep_sel,
  output logic             enb,
  output logic [1:0]       modo,
  output logic [3:0]       A,
  output logic [3:0]       B,
  input  logic [3:0]       Q,
  input  logic             RCO,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             pass
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam logic [1:0] MODO_ADD = 2'b00;
  localparam logic [1:0] MODO_SUB = 2'b01;
  localparam logic [2:0] LAT_M1   = 3'(LAT - 1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [1:0]       modo_q, modo_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic             both_q, both_d;   // sweep_sel[1] captured at start

  logic       mismatch;
  logic       halt;
  logic [4:0] sum;
  logic [3:0] diff;

  // Golden model: compare the unit's response with the expected result.
  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, b_q};
    diff = a_q - b_q;
    if (modo_q == MODO_ADD) begin
      mismatch = ({RCO, Q} != sum);
    end else begin
      mismatch = (Q != diff) || (RCO != (a_q < b_q));
    end
`ifdef ARITH_SEQ_STOP_ON_ERR_EN
    halt = mismatch;
`else
    halt = 1'b0;
`endif
  end

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      modo_q  <= MODO_ADD;
      err_q   <= '0;
      pass_q  <= 1'b0;
      both_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      modo_q  <= modo_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      both_q  <= both_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    modo_d  = modo_q;
    err_d   = err_q;
    pass_d  = pass_q;
    both_d  = both_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          both_d  = sweep_sel[1];
          modo_d  = (sweep_sel == 2'b01) ? MODO_SUB : MODO_ADD;
        end
      end

      DRIVE, NEXT: begin
        cnt_d   = LAT_M1;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      CHECK: begin
        if (mismatch && (err_q != {ERR_W{1'b1}})) begin
          err_d = err_q + ERR_W'(1);
        end
        if (halt) begin
          // Failing vector stays on A/B/modo until the next start.
          state_d = FIN;
          pass_d  = 1'b0;
        end else if ((a_q == 4'hF) && (b_q == 4'hF)) begin
          if (both_q && (modo_q == MODO_ADD)) begin
            modo_d  = MODO_SUB;
            a_d     = '0;
            b_d     = '0;
            state_d = NEXT;
          end else begin
            // Final pair stays visible on A/B after the sweep.
            state_d = FIN;
            pass_d  = (err_d == '0);
          end
        end else begin
          b_d = b_q + 4'd1;
          if (b_q == 4'hF) begin
            a_d = a_q + 4'd1;
          end
          state_d = NEXT;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    enb  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      DRIVE, WAIT, CHECK, NEXT: begin
        enb  = 1'b1;
        busy = 1'b1;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
        enb  = 1'b0;
      end
    endcase
  end

  assign modo    = modo_q;
  assign A       = a_q;
  assign B       = b_q;
  assign err_cnt = err_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_arith_seq_checker.sv
// Bench for arith_seq_checker: three instances (LAT=1/ERR_W=8, LAT=3/ERR_W=8,
// LAT=1/ERR_W=4) each face a delayed model of the arithmetic unit with a
// selectable fault. Sweep rows come from a table; end-of-sweep expectations
// go through a scoreboard queue popped when done pulses.
module tb_arith_seq_checker;

  localparam logic [1:0] F_NONE  = 2'd0;  // correct unit
  localparam logic [1:0] F_RCO0  = 2'd1;  // RCO stuck at 0
  localparam logic [1:0] F_QZERO = 2'd2;  // Q stuck at 0

  typedef struct {
    logic [1:0] sel;
    logic [1:0] fault;
    int         err8;   // expected err_cnt, ERR_W=8 instances
    int         err4;   // expected err_cnt, ERR_W=4 instance
    int         pass;
    int         cyc1;   // busy cycles, LAT=1
    int         cyc3;   // busy cycles, LAT=3
    int         a;
    int         b;
    int         modo;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] sweep_sel = 2'b00;
  logic [1:0] fault = F_NONE;

  logic enb1, enb3, enb4, busy1, busy3, busy4, done1, done3, done4;
  logic pass1, pass3, pass4, rco1, rco3, rco4;
  logic [1:0] modo1, modo3, modo4;
  logic [3:0] a1, a3, a4, b1, b3, b4, q1, q3, q4;
  logic [7:0] err1, err3;
  logic [3:0] err4;

  logic [8:0] p1 = '0, p4 = '0, p3a = '0, p3b = '0, p3c = '0;

  int checks = 0;
  int errors = 0;
  int bc1 = 0, bc3 = 0, bc4 = 0;   // cumulative busy cycles
  int dn1 = 0, dn3 = 0, dn4 = 0;   // cumulative done cycles
  row_t tbl [5];
  row_t sb [$];

  always #5 clk = ~clk;

  arith_seq_checker #(.LAT(1), .ERR_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep_sel(sweep_sel),
    .enb(enb1), .modo(modo1), .A(a1), .B(b1), .Q(q1), .RCO(rco1),
    .busy(busy1), .done(done1), .err_cnt(err1), .pass(pass1));

  arith_seq_checker #(.LAT(3), .ERR_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep_sel(sweep_sel),
    .enb(enb3), .modo(modo3), .A(a3), .B(b3), .Q(q3), .RCO(rco3),
    .busy(busy3), .done(done3), .err_cnt(err3), .pass(pass3));

  arith_seq_checker #(.LAT(1), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep_sel(sweep_sel),
    .enb(enb4), .modo(modo4), .A(a4), .B(b4), .Q(q4), .RCO(rco4),
    .busy(busy4), .done(done4), .err_cnt(err4), .pass(pass4));

  // Arithmetic unit response to {sub, A, B}, with the requested fault.
  function automatic logic [4:0] arith(input logic [8:0] v, input logic [1:0] f);
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] r;
    a = v[7:4];
    b = v[3:0];
    if (v[8]) r = {(a < b), 4'(a - b)};
    else      r = {1'b0, a} + {1'b0, b};
    if (f == F_RCO0)  r[4]   = 1'b0;
    if (f == F_QZERO) r[3:0] = 4'h0;
    return r;
  endfunction

  // Vector expected after v = {modo, A, B} in a sweep.
  function automatic logic [9:0] succ(input logic [9:0] v);
    logic [3:0] a;
    logic [3:0] b;
    a = v[7:4];
    b = v[3:0];
    if (a == 4'hF && b == 4'hF) return {2'b01, 8'h00};
    return {v[9:8], (b == 4'hF) ? 4'(a + 4'd1) : a, 4'(b + 4'd1)};
  endfunction

  // Unit models: response appears LAT clock edges after the operands.
  always @(posedge clk) begin
    p1  <= {modo1[0], a1, b1};
    p4  <= {modo4[0], a4, b4};
    p3a <= {modo3[0], a3, b3};
    p3b <= p3a;
    p3c <= p3b;
  end
  assign {rco1, q1} = arith(p1, fault);
  assign {rco4, q4} = arith(p4, fault);
  assign {rco3, q3} = arith(p3c, fault);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Cycle counters and end-of-sweep scoreboard for dut1.
  always @(negedge clk) begin
    if (busy1) bc1++;
    if (busy3) bc3++;
    if (busy4) bc4++;
    if (done3) dn3++;
    if (done4) dn4++;
    if (done1) begin
      dn1++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        row_t e;
        e = sb.pop_front();
        check("err_cnt_lat1", int'(err1), e.err8);
        check("pass_lat1", int'(pass1), e.pass);
        check("final_a", int'(a1), e.a);
        check("final_b", int'(b1), e.b);
        check("final_modo", int'(modo1), e.modo);
      end
    end
  end

  // Operand order monitor for dut1.
  logic [9:0] prev_v;
  bit prev_ok = 1'b0;
  always @(negedge clk) begin
    logic [9:0] cur;
    cur = {modo1, a1, b1};
    if (busy1) begin
      if (!prev_ok) check("sweep_entry", int'(cur), (sweep_sel == 2'b01) ? 256 : 0);
      else if (cur != prev_v) check("vec_order", int'(cur), int'(succ(prev_v)));
      prev_v  = cur;
      prev_ok = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  task automatic check_reset_outputs();
    check("rst_enb", int'({enb1, enb3, enb4}), 0);
    check("rst_busy", int'({busy1, busy3, busy4}), 0);
    check("rst_done", int'({done1, done3, done4}), 0);
    check("rst_pass", int'({pass1, pass3, pass4}), 0);
    check("rst_modo", int'({modo1, modo3, modo4}), 0);
    check("rst_ab", int'({a1, b1, a3, b3, a4, b4}), 0);
    check("rst_err", int'({err1, err3, err4}), 0);
  endtask

  // Run one table row; fin_start also pulses start during dut1's FIN cycle.
  task automatic run_row(input int idx, input bit fin_start);
    row_t e;
    int b1_0, b3_0, b4_0, d1_0, d3_0, d4_0;
    bit fired;
    bit finished;
    e = tbl[idx];
    b1_0 = bc1; b3_0 = bc3; b4_0 = bc4;
    d1_0 = dn1; d3_0 = dn3; d4_0 = dn4;
    fired = 1'b0;
    finished = 1'b0;
    sweep_sel = e.sel;
    fault = e.fault;
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk) start = 1'b1;   // arrives mid-sweep: must be ignored
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk);
      if (fin_start && done1 && !fired) begin
        fired = 1'b1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) check("fin_start_ignored", int'(busy1), 0);
      end
      if (dn1 > d1_0 && dn3 > d3_0 && dn4 > d4_0) begin
        finished = 1'b1;
        break;
      end
    end
    check("sweep_timeout", int'(finished), 1);
    @(negedge clk);
    @(negedge clk);
    check("busy_cycles_lat1", bc1 - b1_0, e.cyc1);
    check("busy_cycles_lat3", bc3 - b3_0, e.cyc3);
    check("busy_cycles_w4", bc4 - b4_0, e.cyc1);
    check("done_pulses_lat1", dn1 - d1_0, 1);
    check("done_pulses_lat3", dn3 - d3_0, 1);
    check("done_pulses_w4", dn4 - d4_0, 1);
    check("err_cnt_lat3", int'(err3), e.err8);
    check("err_cnt_w4", int'(err4), e.err4);
    check("pass_lat3", int'(pass3), e.pass);
    check("pass_w4", int'(pass4), e.pass);
    check("pass_held_lat1", int'(pass1), e.pass);
  endtask

  initial begin
    int d1_0;
    bit hit;
    //        sel    fault    err8 err4 pass cyc1  cyc3  a   b   modo
    tbl[0] = '{2'b00, F_NONE,  0,   0,   1,   768,  1280, 15, 15, 0};
    tbl[1] = '{2'b10, F_NONE,  0,   0,   1,   1536, 2560, 15, 15, 1};
`ifdef ARITH_SEQ_STOP_ON_ERR_EN
    tbl[2] = '{2'b01, F_RCO0,  1,   1,   0,   6,    10,   0,  1,  1};
    tbl[3] = '{2'b11, F_QZERO, 1,   1,   0,   6,    10,   0,  1,  0};
    tbl[4] = '{2'b00, F_QZERO, 1,   1,   0,   6,    10,   0,  1,  0};
`else
    tbl[2] = '{2'b01, F_RCO0,  120, 15,  0,   768,  1280, 15, 15, 1};
    tbl[3] = '{2'b11, F_QZERO, 255, 15,  0,   1536, 2560, 15, 15, 1};
    tbl[4] = '{2'b00, F_QZERO, 240, 15,  0,   768,  1280, 15, 15, 0};
`endif

    #3 check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_row(i, 1'b0);

    // Reset asserted mid-sweep (dut1 at A=7): immediate abort, no done.
    sweep_sel = 2'b00;
    fault = F_NONE;
    d1_0 = dn1;
    hit = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (a1 == 4'd7) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_a7", int'(hit), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_on_abort", dn1 - d1_0, 0);
    check("idle_after_abort", int'({busy1, busy3, busy4}), 0);

    run_row(0, 1'b0);   // clean sweep after the abort
    run_row(0, 1'b1);   // start coincident with FIN

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
